servo_pwm_array: RTL and testbench

// - N-channel servo PWM generator: one shared frame counter drives N_CH independent pulse outputs.
// - Per-channel targets are written over a simple write port and clamped to [MIN_PULSE, MAX_PULSE].
// - Targets are applied only at frame boundaries, optionally slew-limited, so no output ever sees a torn pulse.
// - Sits between the control logic (angle writer) and the servo pins; replaces per-servo single-channel PWM instances.

---
 rtl/servo_pkg.sv | 22 ++
 rtl/servo_slew_ch.sv | 64 ++++++
 rtl/servo_pwm_array.sv | 77 +++++++
 tb/tb_servo_pwm_array.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants and helpers for the servo PWM array.
package servo_pkg;

    localparam int CLK_HZ             = 10_000_000;
    localparam int SERVO_PERIOD       = 200_000;
    localparam int SERVO_CNT_W        = 21;
    localparam int SERVO_MIN_PULSE    = 5_000;
    localparam int SERVO_MAX_PULSE    = 25_000;
    localparam int SERVO_CENTRE_PULSE = 15_000;

    // Unsigned clamp into [lo, hi]; callers zero-extend to 32 bits.
    function automatic logic [31:0] clamp_pulse(
        input logic [31:0] x,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

endpackage

// File: rtl/servo_slew_ch.sv
// One servo channel: clamped target register and frame-synchronous,
// optionally slew-limited, active pulse width.
module servo_slew_ch
    import servo_pkg::*;
#(
    parameter int CNT_W     = SERVO_CNT_W,
    parameter int MIN_PULSE = SERVO_MIN_PULSE,
    parameter int MAX_PULSE = SERVO_MAX_PULSE,
    parameter int RST_PULSE = SERVO_CENTRE_PULSE,
    parameter int STEP      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_pulse,
    input  logic             upd,
    output logic [CNT_W-1:0] active,
    output logic             match
);

    localparam logic [CNT_W-1:0] RST_W  = CNT_W'(RST_PULSE);
    localparam logic [CNT_W-1:0] STEP_W = CNT_W'(STEP);

    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] nxt_active;
    logic [CNT_W-1:0] wr_clamped;

    assign wr_clamped = CNT_W'(clamp_pulse(32'(wr_pulse),
                                           32'(MIN_PULSE),
                                           32'(MAX_PULSE)));

    // Move toward target by at most STEP, never past it.
    always_comb begin
        nxt_active = active;
        if (STEP == 0) begin
            nxt_active = target;
        end else if (target > active) begin
            if ((target - active) > STEP_W)
                nxt_active = active + STEP_W;
            else
                nxt_active = target;
        end else if (target < active) begin
            if ((active - target) > STEP_W)
                nxt_active = active - STEP_W;
            else
                nxt_active = target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target <= RST_W;
            active <= RST_W;
        end else begin
            if (wr)
                target <= wr_clamped;
            if (upd)
                active <= nxt_active;
        end
    end

    assign match = (active == target);

endmodule

// File: rtl/servo_pwm_array.sv
// N-channel servo PWM generator sharing one free-running frame counter;
// pulse widths change only at frame boundaries.
module servo_pwm_array
    import servo_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int CNT_W     = SERVO_CNT_W,
    parameter int PERIOD    = SERVO_PERIOD,
    parameter int MIN_PULSE = SERVO_MIN_PULSE,
    parameter int MAX_PULSE = SERVO_MAX_PULSE,
    parameter int RST_PULSE = SERVO_CENTRE_PULSE,
    parameter int STEP      = 0,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_pulse,
    output logic [N_CH-1:0]  servo,
    output logic             frame_start,
    output logic             settled
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic             frame_end;
    logic [CNT_W-1:0] active [N_CH];
    logic [N_CH-1:0]  match;

    assign frame_end = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            frame_start <= 1'b0;
            settled     <= 1'b1;
        end else begin
            cnt         <= frame_end ? '0 : cnt + CNT_W'(1);
            frame_start <= (cnt == '0);
            settled     <= &match;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr_hit;

        // Out-of-range channel indices match no instance.
        assign wr_hit = wr_en && (wr_ch == CH_W'(i));

        servo_slew_ch #(
            .CNT_W     (CNT_W),
            .MIN_PULSE (MIN_PULSE),
            .MAX_PULSE (MAX_PULSE),
            .RST_PULSE (RST_PULSE),
            .STEP      (STEP)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr       (wr_hit),
            .wr_pulse (wr_pulse),
            .upd      (frame_end),
            .active   (active[i]),
            .match    (match[i])
        );

        always_ff @(posedge clk) begin
            if (rst)
                servo[i] <= 1'b0;
            else
                servo[i] <= en[i] & (cnt < active[i]);
        end
    end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Scoreboard bench: two instances (unlimited and slew-limited) against
// a frame-level reference model with scaled timing.
module tb_servo_pwm_array;

    localparam int N    = 5;
    localparam int W    = 11;
    localparam int P    = 1000;
    localparam int MN   = 50;
    localparam int MX   = 250;
    localparam int RP   = 150;
    localparam int ST   = 10;
    localparam int CH_W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] en;
    logic         wr_en;
    logic [CH_W-1:0] wr_ch;
    logic [W-1:0] wr_pulse;
    logic [N-1:0] servo_w [2];
    logic         fs_w [2];
    logic         st_w [2];

    servo_pwm_array #(
        .N_CH(N), .CNT_W(W), .PERIOD(P), .MIN_PULSE(MN),
        .MAX_PULSE(MX), .RST_PULSE(RP), .STEP(0)
    ) dut0 (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_pulse(wr_pulse), .servo(servo_w[0]),
        .frame_start(fs_w[0]), .settled(st_w[0])
    );

    servo_pwm_array #(
        .N_CH(N), .CNT_W(W), .PERIOD(P), .MIN_PULSE(MN),
        .MAX_PULSE(MX), .RST_PULSE(RP), .STEP(ST)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_pulse(wr_pulse), .servo(servo_w[1]),
        .frame_start(fs_w[1]), .settled(st_w[1])
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] servo;
        logic         fs;
        logic         st;
    } cyc_t;

    typedef struct packed {
        logic [N-1:0][15:0] width;
        logic [15:0]        len;
    } frm_t;

    cyc_t cq [2][$];
    frm_t fq [2][$];

    int compared   = 0;
    int mismatched = 0;
    int nframes    = 0;

    int mcnt = 0;
    int tgt [2][N];
    int act [2][N];
    int acc [2][N];
    bit flush [2];

    function automatic int clampv(int x);
        return (x < MN) ? MN : ((x > MX) ? MX : x);
    endfunction

    function automatic int slew(int a, int t, int s);
        if (s == 0) return t;
        if (t > a) return (t - a > s) ? a + s : t;
        return (a - t > s) ? a - s : t;
    endfunction

    // Reference model: advances one clock edge using the inputs it sampled.
    task automatic model_edge();
        cyc_t c;
        frm_t f;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    tgt[d][i] = RP;
                    act[d][i] = RP;
                    acc[d][i] = 0;
                end
                cq[d].delete();
                fq[d].delete();
                flush[d] = 1'b1;
                c = '{servo: '0, fs: 1'b0, st: 1'b1};
                cq[d].push_back(c);
            end else begin
                c.st = 1'b1;
                c.fs = (mcnt == 0);
                for (int i = 0; i < N; i++) begin
                    if (act[d][i] != tgt[d][i]) c.st = 1'b0;
                    c.servo[i] = en[i] && (mcnt < act[d][i]);
                    if (c.servo[i]) acc[d][i]++;
                end
                cq[d].push_back(c);
                if (mcnt == P - 1) begin
                    for (int i = 0; i < N; i++) begin
                        f.width[i] = 16'(acc[d][i]);
                        acc[d][i] = 0;
                        act[d][i] = slew(act[d][i], tgt[d][i], d ? ST : 0);
                    end
                    f.len = 16'(P);
                    fq[d].push_back(f);
                end
                if (wr_en && int'(wr_ch) < N)
                    tgt[d][wr_ch] = clampv(int'(wr_pulse));
            end
        end
        if (rst) mcnt = 0;
        else mcnt = (mcnt == P - 1) ? 0 : mcnt + 1;
    endtask

    int  hi [2][N];
    int  flen [2];
    bit  open [2];

    always @(negedge clk) begin
        cyc_t c;
        frm_t f;
        for (int d = 0; d < 2; d++) begin
            if (flush[d]) begin
                open[d]  = 1'b0;
                flush[d] = 1'b0;
            end
            if (cq[d].size() != 0) begin
                c = cq[d].pop_front();
                compared++;
                if ({servo_w[d], fs_w[d], st_w[d]} !== c) begin
                    mismatched++;
                    $display("FAIL cycle dut%0d t=%0t got servo=%b fs=%b st=%b exp servo=%b fs=%b st=%b",
                             d, $time, servo_w[d], fs_w[d], st_w[d], c.servo, c.fs, c.st);
                end
            end
            if (fs_w[d] === 1'b1) begin
                if (open[d]) begin
                    compared++;
                    if (fq[d].size() == 0) begin
                        mismatched++;
                        $display("FAIL frame_missing dut%0d t=%0t got frame exp none", d, $time);
                    end else begin
                        f = fq[d].pop_front();
                        nframes++;
                        if (flen[d] != int'(f.len)) begin
                            mismatched++;
                            $display("FAIL frame_len dut%0d got %0d exp %0d", d, flen[d], f.len);
                        end
                        for (int i = 0; i < N; i++) begin
                            compared++;
                            if (hi[d][i] != int'(f.width[i])) begin
                                mismatched++;
                                $display("FAIL width dut%0d ch%0d t=%0t got %0d exp %0d",
                                         d, i, $time, hi[d][i], f.width[i]);
                            end
                        end
                    end
                end
                open[d] = 1'b1;
                flen[d] = 0;
                for (int i = 0; i < N; i++) hi[d][i] = 0;
            end
            if (open[d]) begin
                flen[d]++;
                for (int i = 0; i < N; i++)
                    if (servo_w[d][i] === 1'b1) hi[d][i]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
        wr_en = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic run_to(int c);
        int g = 0;
        while (mcnt != c && g < 2 * P) begin
            tick();
            g++;
        end
    endtask

    task automatic wr(int ch, int v);
        wr_ch    = CH_W'(ch);
        wr_pulse = W'(v);
        wr_en    = 1'b1;
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        en       = '1;
        wr_en    = 1'b0;
        wr_ch    = '0;
        wr_pulse = '0;
        repeat (3) begin
            rst = 1'b1;
            tick();
        end
        repeat (2 * P) tick();
        run_to(500);
        wr(2, 200);
        run_to(20);
        wr(1, 200);
        repeat (7 * P) tick();
        run_to(300);
        wr(0, 10);
        repeat (2 * P) tick();
        run_to(300);
        wr(0, 600);
        repeat (2 * P) tick();
        wr(5, 100);
        wr(7, 30);
        repeat (P) tick();
        run_to(P - 1);
        wr(4, 60);
        repeat (2 * P) tick();
        run_to(50);
        en[3] = 1'b0;
        run_to(100);
        en[3] = 1'b1;
        repeat (2 * P) tick();
        repeat (10 * P) begin
            if ($urandom_range(0, 99) < 2) begin
                wr_ch    = CH_W'($urandom_range(0, 7));
                wr_pulse = W'($urandom_range(0, 2047));
                wr_en    = 1'b1;
            end
            if ($urandom_range(0, 999) < 3)
                en[$urandom_range(0, N - 1)] ^= 1'b1;
            tick();
        end
        en = '1;
        repeat (2 * P) tick();
        run_to(500);
        rst = 1'b1;
        tick();
        repeat (3 * P) tick();
        #3;
        compared++;
        if (nframes < 40) begin
            mismatched++;
            $display("FAIL frames_seen got %0d exp >= 40", nframes);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
